fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/rv_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 50 +++++
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV core definitions: data widths and the fetch FSM state encoding.
package rv_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } fetchStateT;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with flush; head entry and valid come straight from state.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = XLEN + ILEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       pushData,
  input  logic                   pop,
  output logic [WIDTH-1:0]       headData,
  output logic                   headValid,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW:0]      wrPtr;
  logic [PW:0]      rdPtr;
  logic             doPop;

  assign doPop = pop && headValid;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push)  wrPtr <= wrPtr + PTR_ONE;
      if (doPop) rdPtr <= rdPtr + PTR_ONE;
    end
  end

  // NOTE: storage is not reset; the head is masked to zero whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) storage[wrPtr[PW-1:0]] <= pushData;
  end

  assign count     = wrPtr - rdPtr;
  assign headValid = (count != 0);
  assign headData  = headValid ? storage[rdPtr[PW-1:0]] : '0;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request, responses buffered in fetch_fifo.
// Build option FETCH_MISALIGN_CHECK_EN adds a sticky fetch_misaligned flag that halts fetch.
module fetch_unit
  import rv_pkg::*;
#(
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = 64'h0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [ILEN-1:0] mem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            fetch_misaligned
`endif
);
  localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  fetchStateT           state;
  logic [XLEN-1:0]      fetchPc;
  logic [XLEN-1:0]      pendingPc;
  logic [XLEN-1:0]      targetPc;
  logic [CW-1:0]        fifoCount;
  logic [CW-1:0]        countAfterPush;
  logic                 push;
  logic                 popFire;
  logic                 haltQ;
  logic                 badTarget;
  logic [XLEN+ILEN-1:0] headData;

  assign popFire        = inst_valid && inst_ready;
  assign push           = (state == WAIT) && mem_rsp_valid && !redirect;
  assign countAfterPush = fifoCount + CNT_ONE - (popFire ? CNT_ONE : '0);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalignedQ;

  assign targetPc  = redirect_pc;
  assign badTarget = (redirect_pc[1:0] != 2'b00);
  assign haltQ     = misalignedQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           misalignedQ <= 1'b0;
    else if (redirect) misalignedQ <= badTarget;
  end

  assign fetch_misaligned = misalignedQ;
`else
  assign targetPc  = redirect_pc & ~XLEN'(3);
  assign badTarget = 1'b0;
  assign haltQ     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      fetchPc   <= RESET_PC;
      pendingPc <= RESET_PC;
    end else if (redirect) begin
      fetchPc <= targetPc;
      // A response landing with the redirect is stale either way, so it also ends a drain.
      unique case (state)
        WAIT, DRAIN: state <= mem_rsp_valid ? (badTarget ? IDLE : REQ) : DRAIN;
        default:     state <= badTarget ? IDLE : REQ;
      endcase
    end else begin
      unique case (state)
        IDLE:  if (!haltQ && fifoCount < DEPTH_C) state <= REQ;
        REQ: begin
          if (mem_req_ready) begin
            state     <= WAIT;
            pendingPc <= fetchPc;
            fetchPc   <= fetchPc + XLEN'(4);
          end
        end
        WAIT:  if (mem_rsp_valid) state <= (countAfterPush < DEPTH_C) ? REQ : IDLE;
        DRAIN: if (mem_rsp_valid) state <= haltQ ? IDLE : REQ;
        default: state <= IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (XLEN + ILEN)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .pushData  ({pendingPc, mem_rsp_data}),
    .pop       (inst_ready),
    .headData  (headData),
    .headValid (inst_valid),
    .count     (fifoCount)
  );

  assign mem_req_valid   = (state == REQ);
  assign mem_req_addr    = fetchPc;
  assign {inst_pc, inst} = headData;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory responder, stream scoreboard, directed and random phases.
module tb_fetch_unit;
  logic        clk;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  fetch_unit #(.FIFO_DEPTH(4), .RESET_PC(64'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] word;
  } expT;

  int          errors = 0;
  int          checks = 0;
  expT         expQ[$];
  logic [63:0] streamNext;
  logic [63:0] reqExp;
  int          reqSinceFlush;
  int          delivSinceFlush;
  int          delivTotal = 0;

  // Responder knobs
  int unsigned readyPct  = 100;
  int unsigned delayMin  = 0;
  int unsigned delayMax  = 0;
  bit          injectRsp = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] instWord(input logic [63:0] pc);
    return ((pc[31:0] ^ pc[63:32]) * 32'h9E37_79B1) + 32'h13;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitReq(input string name);
    int n = 0;
    while (!mem_req_valid && n < 60) begin
      tick();
      n++;
    end
    check(name, 64'(mem_req_valid), 64'd1);
  endtask

  task automatic waitAddr(input string name, input logic [63:0] addr);
    int n = 0;
    while (!(mem_req_valid && mem_req_addr == addr) && n < 60) begin
      tick();
      n++;
    end
    check(name, 64'(mem_req_valid && mem_req_addr == addr), 64'd1);
  endtask

  task automatic waitInst(input string name);
    int n = 0;
    while (!inst_valid && n < 60) begin
      tick();
      n++;
    end
    check(name, 64'(inst_valid), 64'd1);
  endtask

  // Memory model: one request in flight, answers with instWord(addr) after a random delay.
  initial begin : responder
    bit          reqFire;
    bit          rspFire;
    logic [63:0] reqAddr;
    bit          pend;
    logic [63:0] pendAddr;
    int          delay;
    pend          = 0;
    pendAddr      = '0;
    delay         = 0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      reqFire = mem_req_valid && mem_req_ready && !rst;
      rspFire = mem_rsp_valid;
      reqAddr = mem_req_addr;
      @(posedge clk);
      #2;
      if (rspFire || rst) pend = 0;
      if (reqFire) begin
        pend     = 1;
        pendAddr = reqAddr;
        delay    = int'($urandom_range(delayMax, delayMin));
      end
      mem_req_ready = (redirect && mem_req_valid) ? 1'b0 : ($urandom_range(99, 0) < readyPct);
      if (injectRsp) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEAD_BEEF;
      end else if (pend && delay == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = instWord(pendAddr);
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        if (pend) delay--;
      end
    end
  end

  // Scoreboard: delivered stream and request stream run sequentially from reset or redirect target.
  always @(negedge clk) begin
    expT e;
    if (rst) begin
      expQ.delete();
      streamNext      = 64'h0;
      reqExp          = 64'h0;
      reqSinceFlush   = 0;
      delivSinceFlush = 0;
    end else begin
      if (mem_req_valid && mem_req_ready) begin
        check("req_addr", mem_req_addr, reqExp);
        reqExp = reqExp + 64'd4;
        reqSinceFlush++;
      end
      if (inst_valid && inst_ready) begin
        while (expQ.size() < 4) begin
          expQ.push_back('{streamNext, instWord(streamNext)});
          streamNext = streamNext + 64'd4;
        end
        e = expQ.pop_front();
        check("inst_pc", inst_pc, e.pc);
        check("inst_word", 64'(inst), 64'(e.word));
        delivSinceFlush++;
        delivTotal++;
      end
      if (redirect) begin
        expQ.delete();
        streamNext      = redirect_pc & ~64'h3;
        reqExp          = redirect_pc & ~64'h3;
        reqSinceFlush   = 0;
        delivSinceFlush = 0;
      end
    end
  end

  initial begin
    int startDeliv;
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    inst_ready  = 1'b1;
    tick(3);
    check("rst_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_req_addr", mem_req_addr, 64'h0);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_inst", 64'(inst), 64'd0);
    check("rst_inst_pc", inst_pc, 64'h0);

    // Reset release: first request next cycle, first instruction two cycles after that
    rst = 1'b0;
    tick();
    check("first_req_valid", 64'(mem_req_valid), 64'd1);
    check("first_req_addr", mem_req_addr, 64'h0);
    tick();
    check("lat_n1_valid", 64'(inst_valid), 64'd0);
    tick();
    check("lat_n2_valid", 64'(inst_valid), 64'd1);
    check("lat_n2_pc", inst_pc, 64'h0);
    tick(20);

    // Mid-fetch reset, junk response in the post-release idle cycle, consumer stalled
    rst        = 1'b1;
    inst_ready = 1'b0;
    tick(2);
    rst       = 1'b0;
    injectRsp = 1'b1;
    tick();
    injectRsp = 1'b0;
    tick(15);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("stall_no_req", 64'(mem_req_valid), 64'd0);
    end
    check("buffered", 64'(reqSinceFlush - delivSinceFlush), 64'd4);
    check("stall_head_pc", inst_pc, 64'h0);
    inst_ready = 1'b1;
    waitReq("resume_wait");
    check("resume_addr", mem_req_addr, 64'h10);
    tick(10);

    // Redirect while waiting on 0x8
    rst        = 1'b1;
    inst_ready = 1'b0;
    delayMin   = 3;
    delayMax   = 3;
    tick(2);
    rst = 1'b0;
    waitAddr("wait_req8", 64'h8);
    tick();
    check("pre_flush_valid", 64'(inst_valid), 64'd1);
    redirect    = 1'b1;
    redirect_pc = 64'h100;
    tick();
    redirect = 1'b0;
    check("flush_valid", 64'(inst_valid), 64'd0);
    inst_ready = 1'b1;
    waitReq("wait_req100");
    check("redir_addr", mem_req_addr, 64'h100);
    waitInst("wait_inst100");
    check("redir_inst_pc", inst_pc, 64'h100);
    tick(10);

    // Redirect coincident with response
    delayMin = 0;
    delayMax = 0;
    tick(4);
    waitReq("wait_req_any");
    tick();
    redirect    = 1'b1;
    redirect_pc = 64'h300;
    tick();
    redirect = 1'b0;
    check("coinc_req_valid", 64'(mem_req_valid), 64'd1);
    check("coinc_req_addr", mem_req_addr, 64'h300);

    // Ready held low, then wrap past the top of the address space
    readyPct    = 0;
    redirect    = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", 64'(mem_req_valid), 64'd1);
      check("hold_addr", mem_req_addr, 64'hFFFF_FFFF_FFFF_FFF8);
      tick();
    end
    readyPct = 100;
    waitAddr("wait_fffc", 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    waitReq("wait_wrap");
    check("wrap_addr", mem_req_addr, 64'h0);
    tick(10);

`ifdef FETCH_MISALIGN_CHECK_EN
    redirect    = 1'b1;
    redirect_pc = 64'h102;
    tick();
    redirect = 1'b0;
    check("misalign_set", 64'(fetch_misaligned), 64'd1);
    tick(4);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("misalign_no_req", 64'(mem_req_valid), 64'd0);
    end
    redirect    = 1'b1;
    redirect_pc = 64'h200;
    tick();
    redirect = 1'b0;
    check("misalign_clr", 64'(fetch_misaligned), 64'd0);
    waitReq("wait_req200");
    check("realign_addr", mem_req_addr, 64'h200);
    tick(10);
`endif

    // Random traffic
    readyPct   = 70;
    delayMin   = 0;
    delayMax   = 2;
    startDeliv = delivTotal;
    for (int c = 0; c < 3000; c++) begin
      inst_ready = ($urandom_range(99, 0) < 70);
      redirect   = ($urandom_range(99, 0) < 4);
      if ($urandom_range(3, 0) == 0)
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
      else
        redirect_pc = {$urandom, $urandom};
`ifdef FETCH_MISALIGN_CHECK_EN
      redirect_pc = redirect_pc & ~64'h3;
`endif
      tick();
    end
    redirect   = 1'b0;
    inst_ready = 1'b1;
    tick(30);
    check("random_progress", 64'(delivTotal - startDeliv > 300), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
